// File: rtl/ysyx_22050550_div_issue_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050550_div_issue_pkg
//
// Shared definitions for the EXU-side divider issue block:
//   - op bit positions of the 3-bit EXU op code (rem / unsigned / W-form)
//   - DivSigned encodings presented to the iterative divider
//   - issue FSM state enum
//   - most-negative constants used by the signed-overflow check
//   - operand extension and result formatting helpers
// ----------------------------------------------------------------------------
package ysyx_22050550_div_issue_pkg;

    // Bit positions inside in_op[2:0]
    localparam int OP_REM      = 0;
    localparam int OP_UNSIGNED = 1;
    localparam int OP_W        = 2;

    // Signedness encoding understood by the divider
    localparam logic [1:0] DIV_SIGNED   = 2'b11;
    localparam logic [1:0] DIV_UNSIGNED = 2'b00;

    // Most negative values of the 64-bit and 32-bit forms
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // W-form operands only carry 32 meaningful bits; widen them according to
    // signedness so that the divider and the special-case check can both work
    // on plain 64-bit values.
    function automatic logic [63:0] ext_operand(input logic [63:0] value,
                                                input logic        w_form,
                                                input logic        is_unsigned);
        logic [63:0] result;
        if (!w_form) begin
            result = value;
        end else if (is_unsigned) begin
            result = {32'h0000_0000, value[31:0]};
        end else begin
            result = {{32{value[31]}}, value[31:0]};
        end
        return result;
    endfunction

    // W-form results are always the low word sign-extended, even for DIVUW/REMUW.
    function automatic logic [63:0] fmt_result(input logic [63:0] value,
                                               input logic        w_form);
        logic [63:0] result;
        if (w_form) begin
            result = {{32{value[31]}}, value[31:0]};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/ysyx_22050550_div_special.sv
// ----------------------------------------------------------------------------
// ysyx_22050550_div_special
//
// Combinational detector for the two cases the divider is never asked to
// handle: divide-by-zero and signed overflow (MIN / -1). Works on operands
// that have already been extended to 64 bits, so one comparison covers both
// the 64-bit and the W forms.
//
// Ports:
//   dividend       in  64  extended dividend
//   divisor        in  64  extended divisor
//   op             in  3   [0]=rem, [1]=unsigned, [2]=W-form
//   is_special     out 1   operation resolves without the divider
//   special_value  out 64  raw quotient/remainder (before W formatting)
// ----------------------------------------------------------------------------
module ysyx_22050550_div_special
    import ysyx_22050550_div_issue_pkg::*;
(
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic [2:0]  op,
    output logic        is_special,
    output logic [63:0] special_value
);

    logic        div_by_zero;
    logic        overflow;
    logic [63:0] min_of_form;

    // The signed W-form minimum appears sign-extended after operand extension.
    assign min_of_form = op[OP_W] ? {{32{1'b1}}, MIN32} : MIN64;

    assign div_by_zero = (divisor == 64'd0);
    assign overflow    = !op[OP_UNSIGNED] && (divisor == {64{1'b1}}) &&
                         (dividend == min_of_form);
    assign is_special  = div_by_zero || overflow;

    always_comb begin
        special_value = 64'd0;
        if (div_by_zero) begin
            special_value = op[OP_REM] ? dividend : {64{1'b1}};
        end else if (overflow) begin
            special_value = op[OP_REM] ? 64'd0 : dividend;
        end
    end

endmodule

// File: rtl/ysyx_22050550_div_issue.sv
// ----------------------------------------------------------------------------
// ysyx_22050550_div_issue
//
// EXU-side initiator for the iterative divider. Accepts one RV64M div/rem
// op, extends the operands, drives the divider request for the whole
// operation and returns the selected, formatted result. Divide-by-zero and
// signed overflow are answered locally without touching the divider.
//
// Optional feature (macro YSYX_22050550_DIV_REUSE_EN): remembers the last
// divider operands and both results, so e.g. DIV followed by REM on the
// same operands completes in one cycle without a new divider run.
//
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   in_valid/in_ready     op handshake from the EXU
//   in_op                 [0]=rem, [1]=unsigned, [2]=W-form
//   in_src1, in_src2      dividend, divisor
//   flush                 kills the in-flight op at any point
//   out_valid/out_ready   result handshake, out_result is the rd value
//   busy                  pipeline stall (state != IDLE)
//   io_Div_*              divider request / response interface
// ----------------------------------------------------------------------------
module ysyx_22050550_div_issue
    import ysyx_22050550_div_issue_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy,
    output logic            io_Div_DivValid,
    output logic            io_Div_Flush,
    output logic            io_Div_Divw,
    output logic [1:0]      io_Div_DivSigned,
    output logic [XLEN-1:0] io_Div_Divdend,
    output logic [XLEN-1:0] io_Div_Divisor,
    input  logic            io_Div_DivReady,
    input  logic            io_Div_OutValid,
    input  logic [XLEN-1:0] io_Div_Quotient,
    input  logic [XLEN-1:0] io_Div_Remainder
);

    state_t          state_reg;
    logic            op_rem_reg;

    logic [XLEN-1:0] ext_src1;
    logic [XLEN-1:0] ext_src2;
    logic            is_special;
    logic [XLEN-1:0] special_value;
    logic            cache_hit;
    logic [XLEN-1:0] cache_value;
    logic [XLEN-1:0] wait_value;
    logic            accept;
    logic            div_done;

    assign ext_src1 = ext_operand(in_src1, in_op[OP_W], in_op[OP_UNSIGNED]);
    assign ext_src2 = ext_operand(in_src2, in_op[OP_W], in_op[OP_UNSIGNED]);

    ysyx_22050550_div_special u_special (
        .dividend      (ext_src1),
        .divisor       (ext_src2),
        .op            (in_op),
        .is_special    (is_special),
        .special_value (special_value)
    );

    assign accept     = (state_reg == IDLE) && in_valid && !flush;
    assign div_done   = (state_reg == WAIT) && io_Div_OutValid && !flush;
    assign wait_value = op_rem_reg ? io_Div_Remainder : io_Div_Quotient;

    // ------------------------------------------------------------------
    // Result reuse cache
    // ------------------------------------------------------------------
`ifdef YSYX_22050550_DIV_REUSE_EN
    logic            cache_valid_reg;
    logic [XLEN-1:0] cache_dividend_reg;
    logic [XLEN-1:0] cache_divisor_reg;
    logic            cache_unsigned_reg;
    logic            cache_w_reg;
    logic [XLEN-1:0] cache_quot_reg;
    logic [XLEN-1:0] cache_rem_reg;

    // Capture from the registered divider inputs, which are exactly what the
    // divider computed on. A flushed op never reaches div_done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cache_valid_reg    <= 1'b0;
            cache_dividend_reg <= '0;
            cache_divisor_reg  <= '0;
            cache_unsigned_reg <= 1'b0;
            cache_w_reg        <= 1'b0;
            cache_quot_reg     <= '0;
            cache_rem_reg      <= '0;
        end else if (div_done) begin
            cache_valid_reg    <= 1'b1;
            cache_dividend_reg <= io_Div_Divdend;
            cache_divisor_reg  <= io_Div_Divisor;
            cache_unsigned_reg <= (io_Div_DivSigned == DIV_UNSIGNED);
            cache_w_reg        <= io_Div_Divw;
            cache_quot_reg     <= io_Div_Quotient;
            cache_rem_reg      <= io_Div_Remainder;
        end
    end

    assign cache_hit   = cache_valid_reg &&
                         (ext_src1 == cache_dividend_reg) &&
                         (ext_src2 == cache_divisor_reg) &&
                         (in_op[OP_UNSIGNED] == cache_unsigned_reg) &&
                         (in_op[OP_W] == cache_w_reg);
    assign cache_value = in_op[OP_REM] ? cache_rem_reg : cache_quot_reg;
`else
    assign cache_hit   = 1'b0;
    assign cache_value = '0;
`endif

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            op_rem_reg       <= 1'b0;
            out_result       <= '0;
            io_Div_Divw      <= 1'b0;
            io_Div_DivSigned <= DIV_UNSIGNED;
            io_Div_Divdend   <= '0;
            io_Div_Divisor   <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_rem_reg <= in_op[OP_REM];
                        if (is_special) begin
                            out_result <= fmt_result(special_value, in_op[OP_W]);
                            state_reg  <= DONE;
                        end else if (cache_hit) begin
                            out_result <= fmt_result(cache_value, in_op[OP_W]);
                            state_reg  <= DONE;
                        end else begin
                            // The divider samples these combinationally for
                            // its whole run, so they are only loaded here.
                            io_Div_Divw      <= in_op[OP_W];
                            io_Div_DivSigned <= in_op[OP_UNSIGNED] ? DIV_UNSIGNED : DIV_SIGNED;
                            io_Div_Divdend   <= ext_src1;
                            io_Div_Divisor   <= ext_src2;
                            state_reg        <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else if (io_Div_OutValid) begin
                        out_result <= fmt_result(wait_value, io_Div_Divw);
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);

    // Request is held for all of WAIT. On a flush before the divider has
    // started, simply withdrawing the request is enough; once it is running,
    // Flush is pulsed alongside the request. When the result is already on
    // the bus the request alone returns the divider to idle.
    assign io_Div_DivValid = (state_reg == WAIT) &&
                             !(flush && io_Div_DivReady && !io_Div_OutValid);
    assign io_Div_Flush    = (state_reg == WAIT) && flush &&
                             !io_Div_DivReady && !io_Div_OutValid;

endmodule

// File: tb/tb_ysyx_22050550_div_issue.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050550_div_issue
//
// Self-checking bench: a behavioural iterative divider with programmable
// latency answers the io_Div_* requests, and a RISC-V M-extension reference
// model provides every expected rd value.
// ----------------------------------------------------------------------------
module tb_ysyx_22050550_div_issue;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        busy;
    logic        io_Div_DivValid;
    logic        io_Div_Flush;
    logic        io_Div_Divw;
    logic [1:0]  io_Div_DivSigned;
    logic [63:0] io_Div_Divdend;
    logic [63:0] io_Div_Divisor;
    logic        io_Div_DivReady;
    logic        io_Div_OutValid;
    logic [63:0] io_Div_Quotient;
    logic [63:0] io_Div_Remainder;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    ysyx_22050550_div_issue #(.XLEN(64)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_op            (in_op),
        .in_src1          (in_src1),
        .in_src2          (in_src2),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .busy             (busy),
        .io_Div_DivValid  (io_Div_DivValid),
        .io_Div_Flush     (io_Div_Flush),
        .io_Div_Divw      (io_Div_Divw),
        .io_Div_DivSigned (io_Div_DivSigned),
        .io_Div_Divdend   (io_Div_Divdend),
        .io_Div_Divisor   (io_Div_Divisor),
        .io_Div_DivReady  (io_Div_DivReady),
        .io_Div_OutValid  (io_Div_OutValid),
        .io_Div_Quotient  (io_Div_Quotient),
        .io_Div_Remainder (io_Div_Remainder)
    );

    // ---------------- reference model (RISC-V M semantics) ----------------
    function automatic logic [63:0] ref_model(input logic [2:0] op,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (op[2]) begin
            if (b32 == 32'd0)
                r32 = op[0] ? a32 : 32'hFFFF_FFFF;
            else if (!op[1] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = op[0] ? 32'd0 : a32;
            else if (op[1])
                r32 = op[0] ? (a32 % b32) : (a32 / b32);
            else
                r32 = op[0] ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
            r64 = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0)
                r64 = op[0] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
            else if (!op[1] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
                r64 = op[0] ? 64'd0 : a;
            else if (op[1])
                r64 = op[0] ? (a % b) : (a / b);
            else
                r64 = op[0] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
        end
        return r64;
    endfunction

    // ---------------- behavioural divider ----------------
    function automatic logic [127:0] stub_divide(input logic [63:0] a, input logic [63:0] b,
                                                 input logic w, input logic sgn);
        logic [63:0] q, r;
        logic [31:0] q32, r32;
        q = '1; r = a; q32 = '1; r32 = a[31:0];
        if (w) begin
            if (b[31:0] != 32'd0) begin
                if (sgn && b[31:0] == 32'hFFFF_FFFF) begin
                    q32 = 32'd0 - a[31:0]; r32 = 32'd0;
                end else if (sgn) begin
                    q32 = 32'($signed(a[31:0]) / $signed(b[31:0]));
                    r32 = 32'($signed(a[31:0]) % $signed(b[31:0]));
                end else begin
                    q32 = a[31:0] / b[31:0];
                    r32 = a[31:0] % b[31:0];
                end
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else if (b != 64'd0) begin
            if (sgn && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = 64'd0 - a; r = 64'd0;
            end else if (sgn) begin
                q = 64'($signed(a) / $signed(b));
                r = 64'($signed(a) % $signed(b));
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        return {q, r};
    endfunction

    logic div_busy;
    int   div_cnt;
    int   div_lat = 3;
    int   div_starts = 0;
    int   dv_gaps = 0;

    assign io_Div_DivReady = !div_busy;
    assign io_Div_OutValid = div_busy && (div_cnt == 0);
    assign {io_Div_Quotient, io_Div_Remainder} =
        stub_divide(io_Div_Divdend, io_Div_Divisor, io_Div_Divw, io_Div_DivSigned == 2'b11);

    // The divider only advances while the request is held.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_busy <= 1'b0;
            div_cnt  <= 0;
        end else if (!div_busy) begin
            if (io_Div_DivValid) begin
                div_busy   <= 1'b1;
                div_cnt    <= div_lat;
                div_starts <= div_starts + 1;
            end
        end else if (io_Div_Flush) begin
            div_busy <= 1'b0;
        end else if (io_Div_DivValid) begin
            if (div_cnt == 0) div_busy <= 1'b0;
            else              div_cnt  <= div_cnt - 1;
        end
    end

    // Any cycle where the divider is mid-operation without a request.
    always @(negedge clock) begin
        if (reset && div_busy && !io_Div_DivValid) dv_gaps <= dv_gaps + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [63:0] last_result, res_first;
    logic        last_valid, cap_divw, cap_dv, stall_ok;
    logic [63:0] cap_dividend;
    int          last_cycles;

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int lat, input int hold);
        int n;
        @(negedge clock);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; div_lat = lat;
        @(negedge clock);
        in_valid = 1'b0;
        n = 1;
        cap_divw = io_Div_Divw; cap_dividend = io_Div_Divdend; cap_dv = io_Div_DivValid;
        while (!out_valid && n < 300) begin
            @(negedge clock);
            n++;
        end
        last_cycles = n;
        last_valid  = out_valid;
        res_first   = out_result;
        stall_ok    = 1'b1;
        repeat (hold) begin
            @(negedge clock);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== res_first) stall_ok = 1'b0;
        end
        last_result = out_result;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'($urandom_range(0, 50));
            1: v = {$urandom, $urandom};
            2: v = 64'd0;
            3: v = 64'hFFFF_FFFF_FFFF_FFFF;
            4: v = 64'h8000_0000_0000_0000;
            5: v = {$urandom, 32'h8000_0000};
            default: v = 64'(-$signed(64'($urandom_range(1, 1000))));
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int          s, g;
    logic [2:0]  rop;
    logic [63:0] ra, rb;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_src1 = '0; in_src2 = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_div_ctrl", {58'd0, io_Div_DivValid, io_Div_Flush, io_Div_Divw, io_Div_DivSigned, 1'b0}, 64'd0);
        check("rst_div_ops", io_Div_Divdend | io_Div_Divisor, 64'd0);
        reset = 1'b1;

        // DIV signed 64: -20 / 3
        s = div_starts; g = dv_gaps;
        run_op(3'b000, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 6, 0);
        check("div_s64", last_result, 64'hFFFF_FFFF_FFFF_FFFA);
        check("div_s64_valid", 64'(last_valid), 64'd1);
        check("div_s64_starts", 64'(div_starts - s), 64'd1);
        check("div_s64_gaps", 64'(dv_gaps - g), 64'd0);

        // REMUW: zero-extended dividend on the bus
        run_op(3'b111, 64'hFFFF_FFFF_0000_0007, 64'd2, 3, 0);
        check("remuw", last_result, ref_model(3'b111, 64'hFFFF_FFFF_0000_0007, 64'd2));
        check("remuw_divw", 64'(cap_divw), 64'd1);
        check("remuw_divdend", cap_dividend, 64'd7);

        // DIVW with sign-extended result
        run_op(3'b100, 64'h0000_0000_8000_0000, 64'd1, 2, 0);
        check("divw", last_result, 64'hFFFF_FFFF_8000_0000);

        // Special cases: one cycle, divider untouched
        s = div_starts;
        run_op(3'b010, 64'h1234_5678_9ABC_DEF0, 64'd0, 2, 0);
        check("divu_zero", last_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("divu_zero_lat", 64'(last_cycles), 64'd1);
        check("divu_zero_dv", 64'(cap_dv), 64'd0);
        run_op(3'b001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        check("rem_ovf", last_result, 64'd0);
        check("rem_ovf_lat", 64'(last_cycles), 64'd1);
        run_op(3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2, 0);
        check("divw_ovf", last_result, 64'hFFFF_FFFF_8000_0000);
        check("special_no_div", 64'(div_starts - s), 64'd0);

        // Flush in the first WAIT cycle: request withdrawn, no Flush pulse
        s = div_starts;
        @(negedge clock);
        in_valid = 1'b1; in_op = 3'b000; in_src1 = 64'd50; in_src2 = 64'd5; div_lat = 5;
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b1; #1;
        check("fl0_divvalid", 64'(io_Div_DivValid), 64'd0);
        check("fl0_flush", 64'(io_Div_Flush), 64'd0);
        @(negedge clock);
        flush = 1'b0; #1;
        check("fl0_idle", 64'(in_ready), 64'd1);
        check("fl0_no_div", 64'(div_starts - s), 64'd0);

        // Flush ten cycles into WAIT: single Flush pulse with the request
        @(negedge clock);
        in_valid = 1'b1; in_op = 3'b001; in_src1 = 64'd12345; in_src2 = 64'd77; div_lat = 30;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        flush = 1'b1; #1;
        check("fl10_divvalid", 64'(io_Div_DivValid), 64'd1);
        check("fl10_flush", 64'(io_Div_Flush), 64'd1);
        @(negedge clock);
        flush = 1'b0; #1;
        check("fl10_divready", 64'(io_Div_DivReady), 64'd1);
        check("fl10_flush_off", 64'(io_Div_Flush), 64'd0);
        check("fl10_idle", {62'd0, in_ready, out_valid}, 64'd2);
        run_op(3'b010, 64'd999, 64'd10, 4, 0);
        check("after_flush", last_result, 64'd99);

        // Backpressure: result held while out_ready is low
        run_op(3'b011, 64'd1000, 64'd7, 2, 5);
        check("bp_stall", 64'(stall_ok), 64'd1);
        check("bp_result", last_result, 64'd6);

        // DIV then REM on the same operands
        run_op(3'b000, 64'd100, 64'd7, 3, 0);
        check("reuse_div", last_result, 64'd14);
        s = div_starts;
        run_op(3'b001, 64'd100, 64'd7, 3, 0);
        check("reuse_rem", last_result, 64'd2);
`ifdef YSYX_22050550_DIV_REUSE_EN
        check("reuse_lat", 64'(last_cycles), 64'd1);
        check("reuse_no_div", 64'(div_starts - s), 64'd0);
`else
        check("reuse_div_run", 64'(div_starts - s), 64'd1);
        check("reuse_dv", 64'(cap_dv), 64'd1);
`endif

        // Randomized ops against the reference model
        g = dv_gaps;
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)));
            check($sformatf("rand%0d_op%0d", i, rop), last_result, ref_model(rop, ra, rb));
        end
        check("rand_gaps", 64'(dv_gaps - g), 64'd0);

        // Reset asserted mid-WAIT
        @(negedge clock);
        in_valid = 1'b1; in_op = 3'b000; in_src1 = 64'd1000; in_src2 = 64'd7; div_lat = 30;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("amid_state", {60'd0, in_ready, out_valid, busy, io_Div_DivValid}, 64'd8);
        check("amid_result", out_result, 64'd0);
        check("amid_ctrl", {60'd0, io_Div_Flush, io_Div_Divw, io_Div_DivSigned}, 64'd0);
        check("amid_ops", io_Div_Divdend | io_Div_Divisor, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        run_op(3'b000, 64'd1000, 64'd7, 2, 0);
        check("after_reset", last_result, 64'd142);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
